// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared types and SSD1306 command constants for the SPI transmitter, its drivers and benches
package ssd1306_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} tx_state_t;
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } ssd1306_word_t;
  localparam logic [7:0] CMD_DISPLAY_RESUME = 8'hA4;
  localparam logic [7:0] CMD_DISPLAY_ALL_ON = 8'hA5;
  localparam logic [7:0] CMD_NORMAL         = 8'hA6;
  localparam logic [7:0] CMD_INVERT         = 8'hA7;
  localparam logic [7:0] CMD_DISPLAY_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON     = 8'hAF;
  localparam logic [7:0] CMD_SEG_REMAP_0    = 8'hA0;
  localparam logic [7:0] CMD_SEG_REMAP_1    = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_INC   = 8'hC0;
  localparam logic [7:0] CMD_COM_SCAN_DEC   = 8'hC8;
  localparam logic [7:0] CMD_MEM_MODE       = 8'h20;
  localparam logic [7:0] CMD_PAGE_BASE      = 8'hB0;
  function automatic logic [7:0] page_cmd(input logic [2:0] page);
    return CMD_PAGE_BASE | {5'd0, page};
  endfunction
endpackage

// File: rtl/simio_sync_fifo.sv
// simio_sync_fifo: single-clock FIFO with full/empty flags, pointers carry one wrap bit
module simio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + ONE;
    end
  always_ff @(posedge clk_i)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/ssd1306_spi4_tx.sv
// ssd1306_spi4_tx: buffered SPI mode-0 byte transmitter for SSD1306, holds CS low across queued bytes
module ssd1306_spi4_tx
  import ssd1306_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       dc_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       cs_on,
  output logic       sck_o,
  output logic       sdi_o,
  output logic       dc_o
);
  localparam int DW = $clog2(CLK_DIV + 1);
  tx_state_t state;
  ssd1306_word_t wr_word, rd_word;
  logic full, empty, pop, phase_done, frame_end;
  logic [DW-1:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] shifter;
  assign wr_word = '{dc: dc_i, data: data_i};
  assign phase_done = div_cnt == DW'(CLK_DIV - 1);
  assign frame_end = state == LOW && phase_done && bit_cnt == 3'd0;
  assign pop = !empty && (state == IDLE || frame_end);
  assign ready_o = !full;
  assign busy_o = state != IDLE || !empty;
  simio_sync_fifo #(.WIDTH($bits(ssd1306_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .push    (valid_i && !full),
    .pop     (pop),
    .wr_data (wr_word),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= 3'd7;
      shifter <= '0;
      cs_on   <= 1'b1;
      sck_o   <= 1'b0;
      sdi_o   <= 1'b0;
      dc_o    <= 1'b0;
    end else begin
      div_cnt <= (state == IDLE || phase_done) ? '0 : div_cnt + DW'(1);
      // a pop happens from IDLE or at the end of bit 0's LOW, so CS stays low between queued bytes
      if (pop) begin
        state   <= LEAD;
        bit_cnt <= 3'd7;
        shifter <= rd_word.data[6:0];
        sdi_o   <= rd_word.data[7];
        dc_o    <= rd_word.dc;
        cs_on   <= 1'b0;
      end else if (phase_done)
        case (state)
          LEAD: begin
            state <= HIGH;
            sck_o <= 1'b1;
          end
          HIGH: begin
            state <= LOW;
            sck_o <= 1'b0;
            if (bit_cnt != 3'd0) begin
              shifter <= {shifter[5:0], 1'b0};
              sdi_o   <= shifter[6];
            end
          end
          LOW:
            if (bit_cnt == 3'd0) begin
              state <= GAP;
              cs_on <= 1'b1;
            end else begin
              state   <= HIGH;
              sck_o   <= 1'b1;
              bit_cnt <= bit_cnt - 3'd1;
            end
          GAP: state <= IDLE;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_ssd1306_spi4_tx.sv
// tb_ssd1306_spi4_tx: directed bench with an SPI receiver monitor feeding a byte log scored against an expected queue
module tb_ssd1306_spi4_tx;
  import ssd1306_pkg::*;
  logic clk_i = 1'b0, rst_in = 1'b0, valid_i = 1'b0, valid1 = 1'b0, dc_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic ready_o, busy_o, cs_on, sck_o, sdi_o, dc_o;
  logic ready1, busy1, cs1, sck1, sdi1, dc1;
  int checks = 0, failures = 0;
  logic [8:0] exp_q [$];
  logic [8:0] rx_log [0:511];
  int rx_n = 0, rx_rd = 0, nbits = 0, cs_rise = 0;
  logic [7:0] rx_sh = 8'h00;
  logic prev_sck = 1'b0, prev_cs = 1'b1;

  always #5 clk_i = ~clk_i;

  ssd1306_spi4_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .valid_i(valid_i), .ready_o(ready_o), .dc_i(dc_i),
    .data_i(data_i), .busy_o(busy_o), .cs_on(cs_on), .sck_o(sck_o), .sdi_o(sdi_o), .dc_o(dc_o));

  ssd1306_spi4_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut_div1 (
    .clk_i(clk_i), .rst_in(rst_in), .valid_i(valid1), .ready_o(ready1), .dc_i(dc_i),
    .data_i(data_i), .busy_o(busy1), .cs_on(cs1), .sck_o(sck1), .sdi_o(sdi1), .dc_o(dc1));

  // receiver: shift on SCK rise, latch byte and D/C at the 8th fall
  always @(negedge clk_i) begin
    if (!rst_in) begin
      nbits = 0;
      prev_sck = 1'b0;
      prev_cs = 1'b1;
    end else begin
      if (sck_o && !prev_sck) rx_sh = {rx_sh[6:0], sdi_o};
      if (!sck_o && prev_sck) begin
        nbits++;
        if (nbits == 8) begin
          if (rx_n < 512) rx_log[rx_n] = {dc_o, rx_sh};
          rx_n++;
          nbits = 0;
        end
      end
      if (cs_on && !prev_cs) cs_rise++;
      prev_sck = sck_o;
      prev_cs = cs_on;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic dc, input logic [7:0] d);
    int t = 0;
    logic acc;
    valid_i = 1'b1;
    dc_i = dc;
    data_i = d;
    do begin
      acc = ready_o;
      tick();
      t++;
    end while (!acc && t < 1000);
    chk("push_accepted", 32'(acc), 1);
    if (acc) exp_q.push_back({dc, d});
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 5000) begin
      tick();
      t++;
    end
    chk("idle_reached", 32'(busy_o), 0);
    repeat (2) tick();
  endtask

  task automatic score(input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_rd < rx_n) begin
        chk(tag, 32'(rx_log[rx_rd]), 32'(e));
        rx_rd++;
      end else chk({tag, "_missing"}, rx_n, rx_rd + 1);
    end
    chk({tag, "_extra"}, rx_n, rx_rd);
  endtask

  task automatic frame(input bit sel, output int low, output int rises, output logic [7:0] b, output logic dcv);
    int t = 0;
    logic ps = 1'b0, s;
    low = 0;
    rises = 0;
    b = 8'h00;
    dcv = 1'b0;
    while ((sel ? cs1 : cs_on) && t < 1000) begin
      tick();
      t++;
    end
    while (!(sel ? cs1 : cs_on) && low < 1000) begin
      s = sel ? sck1 : sck_o;
      if (s && !ps) begin
        rises++;
        b = {b[6:0], sel ? sdi1 : sdi_o};
        dcv = sel ? dc1 : dc_o;
      end
      ps = s;
      low++;
      tick();
    end
  endtask

  initial begin
    int low, rises, r0, g;
    logic [7:0] b;
    logic dcv;
    repeat (3) tick();
    chk("rst_cs", 32'(cs_on), 1);
    chk("rst_sck", 32'(sck_o), 0);
    chk("rst_sdi", 32'(sdi_o), 0);
    chk("rst_dc", 32'(dc_o), 0);
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_cs_div1", 32'(cs1), 1);
    rst_in = 1'b1;
    tick();

    push(1'b0, CMD_DISPLAY_ON);
    valid_i = 1'b0;
    chk("single_cs_before", 32'(cs_on), 1);
    tick();
    chk("single_cs_fall", 32'(cs_on), 0);
    chk("single_busy", 32'(busy_o), 1);
    frame(1'b0, low, rises, b, dcv);
    chk("single_cs_low_cycles", low, 34);
    chk("single_sck_rises", rises, 8);
    chk("single_byte", 32'(b), 32'hAF);
    chk("single_dc", 32'(dcv), 0);
    wait_idle();
    score("single");

    r0 = cs_rise;
    push(1'b0, CMD_MEM_MODE);
    push(1'b0, 8'h00);
    for (int i = 0; i < 128; i++) push(1'b1, 8'(i));
    valid_i = 1'b0;
    wait_idle();
    chk("b2b_cs_rises", cs_rise - r0, 1);
    score("b2b");

    for (int i = 0; i < 10; i++) begin
      push(1'(i % 2), 8'(8'hC0 + i));
      if (i == 3) chk("bp_ready_high", 32'(ready_o), 1);
      if (i == 4) chk("bp_ready_low", 32'(ready_o), 0);
    end
    valid_i = 1'b0;
    wait_idle();
    chk("bp_ready_restored", 32'(ready_o), 1);
    score("bp");

    r0 = cs_rise;
    push(1'b0, CMD_NORMAL);
    valid_i = 1'b0;
    repeat (33) tick();
    push(1'b1, 8'h5A);
    valid_i = 1'b0;
    wait_idle();
    chk("last_low_cs_rises", cs_rise - r0, 1);
    score("last_low");

    r0 = cs_rise;
    push(1'b0, CMD_INVERT);
    valid_i = 1'b0;
    frame(1'b0, low, rises, b, dcv);
    chk("gap_first_low", low, 34);
    push(1'b1, 8'h33);
    valid_i = 1'b0;
    g = 1;
    while (cs_on && g < 100) begin
      g++;
      tick();
    end
    chk("gap_cs_high_cycles", g, 3);
    wait_idle();
    chk("gap_cs_rises", cs_rise - r0, 2);
    score("gap");

    valid1 = 1'b1;
    dc_i = 1'b1;
    data_i = CMD_DISPLAY_ALL_ON;
    chk("div1_ready", 32'(ready1), 1);
    tick();
    valid1 = 1'b0;
    frame(1'b1, low, rises, b, dcv);
    chk("div1_cs_low_cycles", low, 17);
    chk("div1_sck_rises", rises, 8);
    chk("div1_byte", 32'(b), 32'hA5);
    chk("div1_dc", 32'(dcv), 1);

    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    push(1'b0, 8'h33);
    valid_i = 1'b0;
    repeat (6) tick();
    chk("midrst_cs_low_before", 32'(cs_on), 0);
    #2 rst_in = 1'b0;
    #1;
    chk("midrst_cs_async", 32'(cs_on), 1);
    chk("midrst_sck", 32'(sck_o), 0);
    chk("midrst_sdi", 32'(sdi_o), 0);
    chk("midrst_busy_flushed", 32'(busy_o), 0);
    chk("midrst_ready", 32'(ready_o), 1);
    repeat (2) tick();
    rst_in = 1'b1;
    exp_q.delete();
    rx_rd = rx_n;
    repeat (20) tick();
    chk("post_rst_cs_quiet", 32'(cs_on), 1);
    chk("post_rst_no_bytes", rx_n, rx_rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ssd1306_spi4_tx.md
# ssd1306_spi4_tx

Synthesizable SPI 4-wire transmitter driving an SSD1306 controller (cs_n, sdi, sck, dc). It sits directly upstream of the SSD1306 SPI model. Command and data bytes arrive through a valid/ready stream with a D/C flag, are buffered in a small FIFO, and are serialized in SPI mode 0, MSB first. While the FIFO is non-empty, CS stays low across consecutive bytes.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk_i` cycles; legal values ≥ 1.
- `FIFO_DEPTH`, default 4: entries of {dc, byte}; power of two, ≥ 2.
- `clk_i`  input  1  system clock; all logic on its rising edge.
- `rst_in`  input  1  reset, asynchronous, active-low.
- `valid_i`  input  1  upstream byte valid.
- `ready_o`  output  1  FIFO not full; a byte is accepted when `valid_i && ready_o`.
- `dc_i`  input  1  0 = command, 1 = display data.
- `data_i`  input  8  byte to send.
- `busy_o`  output  1  FIFO non-empty or frame in progress.
- `cs_on`  output  1  chip select, low active.
- `sck_o`  output  1  serial clock; idle low.
- `sdi_o`  output  1  serial data, MSB first.
- `dc_o`  output  1  D/C line to the display.

## Operation
- FSM states: IDLE, LEAD, HIGH, LOW, GAP. A divider counter counts each phase for `CLK_DIV` cycles. A 3-bit bit counter tracks the current bit.
- **IDLE:** `cs_on=1`, `sck_o=0`. If the FIFO is non-empty:
  - pop one entry;
  - load the shifter, set `dc_o`, drive `sdi_o` = bit 7, assert `cs_on=0`;
  - go to LEAD.
- **LEAD:** `sck_o=0` for `CLK_DIV` cycles, then go to HIGH.
- **HIGH:** `sck_o=1` for `CLK_DIV` cycles, then go to LOW.
- **LOW:** `sck_o=0` for `CLK_DIV` cycles.
  - On entry to the LOW that follows bits 7..1, `sdi_o` advances to the next lower bit.
  - After bit 0's LOW, if the FIFO is non-empty: pop, reload the shifter and `dc_o`, keep `cs_on=0`, go to LEAD.
  - Otherwise: set `cs_on=1`, go to GAP.
- **GAP:** `cs_on=1` for `CLK_DIV` cycles, then go to IDLE.
- `dc_o` is stable from LEAD until after the 8th falling SCK edge of the byte. The receiver samples D/C at that edge.
- `dc_o` and `sdi_o` hold their last value while idle.
- `busy_o = (state != IDLE) || !fifo_empty`.
- `ready_o = !fifo_full`. It does not depend on `valid_i`. A pop and a push in the same cycle are both honoured.
- The FIFO preserves byte order and the dc/data pairing. No byte is dropped or duplicated.

## Timing
- Reset values (asserted asynchronously): `cs_on=1`, `sck_o=0`, `sdi_o=0`, `dc_o=0`, `ready_o=1`, `busy_o=0`. The FSM is in IDLE and the FIFO is empty.
- Reset mid-frame aborts the frame and flushes the FIFO. `cs_on` rises immediately, without waiting for a clock.
- Latency: a byte accepted at edge N into an empty, idle block sees `cs_on` fall after edge N+1, and `busy_o=1` from N+1.
- Frame length: (1 + 16)·`CLK_DIV` cycles from the `cs_on` fall to the end of bit 0's LOW.
- Back-to-back bytes cost 17·`CLK_DIV` cycles each with `cs_on` held low. CS high time is at least `CLK_DIV` cycles.
- Edge relationships:
  - `sdi_o` changes only with the SCK fall or at LEAD entry.
  - It is stable for at least `CLK_DIV` cycles before every SCK rise.

## Structure
- Shared package `ssd1306_pkg` holds:
  - the FSM state enum;
  - the packed struct `ssd1306_word_t` {dc, data[7:0]};
  - SSD1306 command constants (0xA4/A5, A6/A7, AE/AF, A0/A1, C0/C8, 0x20, 0xB0 page base), reused by benches and drivers.
- Sub-module `simio_sync_fifo`: generic single-clock FIFO parameterised by width and depth, with async active-low reset and full/empty flags.

## Test plan
- **Reset:** hold `rst_in=0` -> all outputs at the reset values above; assert reset mid-frame -> `cs_on=1` before the next `clk_i` edge.
- **Single command, `CLK_DIV=2`:** push 0xAF with dc=0.
  - `cs_on` falls 1 cycle after the push.
  - 8 SCK pulses, 4 cycles apart; `sdi_o` at the rises is 1,0,1,0,1,1,1,1; `dc_o=0`.
  - `cs_on` rises 34 cycles after falling; the attached model reports onoff=true.
- **Back-to-back stream:** 0x20, 0x00 (dc=0), then 128 data bytes 0x00..0x7F (dc=1).
  - `cs_on` stays low throughout.
  - The model reports horizontal mode and x = 0..127 at y=0, data equal to x.
- **Backpressure, `FIFO_DEPTH=4`:** hold `valid_i=1` over 10 bytes.
  - `ready_o` drops once 4 entries are queued with 1 in the shifter.
  - All 10 bytes are emitted in order with the correct dc.
- **Boundaries:**
  - `CLK_DIV=1`: SCK period 2 cycles, frame 17 cycles.
  - Push arriving in the last LOW cycle: continues without a CS gap.
  - Push during GAP: new frame starts after GAP.
